// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm time keeper.
// The package holds the FSM state encoding, field limits, selection codes and the one-hot field decoder.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_SEC  = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_HOUR = 2'b11;

  // Maps a selection code to the {hour,min,sec} display field it addresses.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      SEL_SEC:  oh = 3'b001;
      SEL_MIN:  oh = 3'b010;
      SEL_HOUR: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up counter used for each alarm time field.
// It wraps from MAX to 0 and has no carry output.
module mod_counter #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: hold, increment, or wrap at MAX.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      if (count_q == WIDTH'(MAX)) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alarm_time_keeper.sv
// Alarm time storage, match detection, ring/snooze state machine and field blanking.
// All outputs come straight from registers.
module alarm_time_keeper
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       upsec,
  input  logic       upmin,
  input  logic       uphour,
  input  logic [1:0] selection,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_en,
  input  logic       ack,
  input  logic       snooze,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic [5:0] alarm_sec,
  output logic       alarm_ring,
  output logic [2:0] blank_mask
);

  localparam int CNT_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;
  logic [CW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic          match_s, match_q, trigger_s;
  logic          ring_q;
  logic          blink_q, blink_d;
  logic [2:0]    blank_q;

  mod_counter #(.MAX(SEC_MAX), .WIDTH(6)) u_sec (
    .clk(clk), .reset(reset), .inc(upsec), .count(alarm_sec)
  );

  mod_counter #(.MAX(MIN_MAX), .WIDTH(6)) u_min (
    .clk(clk), .reset(reset), .inc(upmin), .count(alarm_min)
  );

  mod_counter #(.MAX(HOUR_MAX), .WIDTH(5)) u_hour (
    .clk(clk), .reset(reset), .inc(uphour), .count(alarm_hour)
  );

  // Only the rising edge of match rings, so a steady match or a matching reset stays quiet.
  assign match_s   = alarm_en && (cur_hour == alarm_hour) && (cur_min == alarm_min)
                     && (cur_sec == alarm_sec);
  assign trigger_s = match_s && !match_q;

  // Next state and counter updates; alarm_en low overrides everything.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!alarm_en) begin
      state_d      = IDLE;
      ring_cnt_d   = '0;
      snooze_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_s) begin
            state_d    = RINGING;
            ring_cnt_d = CW'(RING_SECONDS);
          end else begin
            state_d = IDLE;
          end
        end
        RINGING: begin
          if (ack) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
          end else if (snooze) begin
            state_d      = SNOOZED;
            ring_cnt_d   = '0;
            snooze_cnt_d = CW'(SNOOZE_SECONDS);
          end else if (tick_1hz) begin
            if (ring_cnt_q <= CW'(1)) begin
              state_d    = IDLE;
              ring_cnt_d = '0;
            end else begin
              ring_cnt_d = ring_cnt_q - CW'(1);
            end
          end else begin
            state_d = RINGING;
          end
        end
        SNOOZED: begin
          if (ack) begin
            state_d      = IDLE;
            snooze_cnt_d = '0;
          end else if (tick_1hz) begin
            if (snooze_cnt_q <= CW'(1)) begin
              state_d      = RINGING;
              snooze_cnt_d = '0;
              ring_cnt_d   = CW'(RING_SECONDS);
            end else begin
              snooze_cnt_d = snooze_cnt_q - CW'(1);
            end
          end else begin
            state_d = SNOOZED;
          end
        end
        default: begin
          state_d      = IDLE;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end
      endcase
    end
  end

  assign blink_d = tick_1hz ? !blink_q : blink_q;

  // State, counters, match history and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      match_q      <= 1'b1;
      ring_q       <= 1'b0;
      blink_q      <= 1'b0;
      blank_q      <= 3'b000;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      match_q      <= match_s;
      ring_q       <= (state_d == RINGING);
      blink_q      <= blink_d;
      blank_q      <= sel_onehot(selection) & {3{blink_d}};
    end
  end

  assign alarm_ring = ring_q;
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed self-checking bench for alarm_time_keeper with short ring/snooze periods.
module tb_alarm_time_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       upsec = 1'b0, upmin = 1'b0, uphour = 1'b0;
  logic [1:0] selection = 2'b00;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0, cur_sec = 6'd0;
  logic       alarm_en = 1'b0, ack = 1'b0, snooze = 1'b0;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min, alarm_sec;
  logic       alarm_ring;
  logic [2:0] blank_mask;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_blink = 1'b0;

  alarm_time_keeper #(.RING_SECONDS(3), .SNOOZE_SECONDS(2)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .upsec(upsec), .upmin(upmin), .uphour(uphour), .selection(selection),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_en(alarm_en), .ack(ack), .snooze(snooze),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .alarm_ring(alarm_ring), .blank_mask(blank_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    exp_blink = ~exp_blink;
  endtask

  task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hour = h;
    cur_min  = m;
    cur_sec  = s;
  endtask

  // Move time away from 06:30:00 and back to it to produce a fresh match edge.
  task automatic retrigger();
    set_cur(5'd6, 6'd30, 6'd1);
    step();
    set_cur(5'd6, 6'd30, 6'd0);
    step();
  endtask

  initial begin
    #12;
    check("rst_ring", 32'(alarm_ring), 32'd0);
    check("rst_mask", 32'(blank_mask), 32'd0);
    reset = 1'b1;
    step();
    check("rst_hms", {15'd0, alarm_hour, alarm_min, alarm_sec}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      upsec = 1'b1;
      step();
      upsec = 1'b0;
      if (i == 58) check("sec_59", 32'(alarm_sec), 32'd59);
    end
    check("sec_wrap", 32'(alarm_sec), 32'd0);
    for (int i = 0; i < 24; i++) begin
      uphour = 1'b1;
      step();
      uphour = 1'b0;
      if (i == 22) check("hour_23", 32'(alarm_hour), 32'd23);
    end
    check("hour_wrap", 32'(alarm_hour), 32'd0);
    check("min_untouched", 32'(alarm_min), 32'd0);

    for (int i = 0; i < 6; i++) begin
      uphour = 1'b1;
      step();
      uphour = 1'b0;
    end
    for (int i = 0; i < 30; i++) begin
      upmin = 1'b1;
      step();
      upmin = 1'b0;
    end
    check("alarm_0630", {15'd0, alarm_hour, alarm_min, alarm_sec}, {15'd0, 5'd6, 6'd30, 6'd0});

    set_cur(5'd6, 6'd29, 6'd59);
    alarm_en = 1'b1;
    step();
    step();
    check("no_ring_0629", 32'(alarm_ring), 32'd0);
    set_cur(5'd6, 6'd30, 6'd0);
    step();
    check("ring_on_match", 32'(alarm_ring), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_stop", 32'(alarm_ring), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("steady_no_rering", 32'(alarm_ring), 32'd0);

    retrigger();
    check("ring2", 32'(alarm_ring), 32'd1);
    tick();
    check("ring_tick1", 32'(alarm_ring), 32'd1);
    tick();
    check("ring_tick2", 32'(alarm_ring), 32'd1);
    tick();
    check("ring_auto_stop", 32'(alarm_ring), 32'd0);
    step();
    check("ring_stays_idle", 32'(alarm_ring), 32'd0);

    retrigger();
    check("ring3", 32'(alarm_ring), 32'd1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("snooze_off", 32'(alarm_ring), 32'd0);
    tick();
    check("snooze_tick1", 32'(alarm_ring), 32'd0);
    tick();
    check("snooze_rering", 32'(alarm_ring), 32'd1);
    ack = 1'b1;
    snooze = 1'b1;
    step();
    ack = 1'b0;
    snooze = 1'b0;
    check("ack_over_snooze", 32'(alarm_ring), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("ack_snooze_idle", 32'(alarm_ring), 32'd0);

    retrigger();
    check("ring4", 32'(alarm_ring), 32'd1);
    alarm_en = 1'b0;
    step();
    check("en_low_stop", 32'(alarm_ring), 32'd0);
    set_cur(5'd6, 6'd0, 6'd0);
    step();
    alarm_en = 1'b1;
    step();

    selection = 2'b10;
    step();
    check("mask_sel", 32'(blank_mask), exp_blink ? 32'd2 : 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mask_toggle", 32'(blank_mask), exp_blink ? 32'd2 : 32'd0);
    end
    if (!exp_blink) tick();
    selection = 2'b11;
    step();
    check("mask_hour", 32'(blank_mask), 32'd4);
    selection = 2'b01;
    step();
    check("mask_sec", 32'(blank_mask), 32'd1);
    selection = 2'b00;
    step();
    check("mask_none", 32'(blank_mask), 32'd0);

    upsec = 1'b1;
    upmin = 1'b1;
    step();
    upsec = 1'b0;
    upmin = 1'b0;
    check("dual_inc", {15'd0, alarm_hour, alarm_min, alarm_sec}, {15'd0, 5'd6, 6'd31, 6'd1});

    set_cur(5'd6, 6'd31, 6'd2);
    step();
    check("edit_pre", 32'(alarm_ring), 32'd0);
    upsec = 1'b1;
    step();
    upsec = 1'b0;
    check("edit_sec", 32'(alarm_sec), 32'd2);
    step();
    check("edit_trigger", 32'(alarm_ring), 32'd1);

    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ring", 32'(alarm_ring), 32'd0);
    check("async_rst_hms", {15'd0, alarm_hour, alarm_min, alarm_sec}, 32'd0);
    check("async_rst_mask", 32'(blank_mask), 32'd0);
    set_cur(5'd0, 6'd0, 6'd0);
    alarm_en = 1'b1;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rst_match_quiet", 32'(alarm_ring), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
